// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start/data/parity/stop sequencing around an external serializer.
// Optional second stop bit (two_stop input) when UART_TX_TWO_STOP_EN is defined.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  par_en,
    input  logic                  par_typ,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  two_stop,
`endif
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [2:0] STOP1  = 3'd5;
`endif

    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [2:0]        state_reg, state_next;
    logic              par_en_reg;
    logic              par_bit_reg;
    logic [WDOG_W-1:0] wdog_cnt_reg;
    logic              accept;
    logic              wdog_fire;
    logic [2:0]        stop_entry;
`ifdef UART_TX_TWO_STOP_EN
    logic              two_stop_reg;
`endif

    assign accept = data_valid && !busy;

    // Watchdog only fires if the serializer has not flagged its last bit by the final allowed cycle.
    assign wdog_fire = (state_reg == DATA) && !ser_done
                       && (wdog_cnt_reg == WDOG_W'(WDOG_LIMIT - 1));

`ifdef UART_TX_TWO_STOP_EN
    assign stop_entry = two_stop_reg ? STOP1 : STOP;
`else
    assign stop_entry = STOP;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = START;
            START:   state_next = DATA;
            DATA: begin
                if (ser_done)
                    state_next = par_en_reg ? PARITY : stop_entry;
                else if (wdog_fire)
                    state_next = STOP;
            end
            PARITY:  state_next = stop_entry;
`ifdef UART_TX_TWO_STOP_EN
            STOP1:   state_next = STOP;
`endif
            STOP:    state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            wdog_cnt_reg <= '0;
`ifdef UART_TX_TWO_STOP_EN
            two_stop_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                par_en_reg  <= par_en;
                par_bit_reg <= (^P_DATA) ^ par_typ;
`ifdef UART_TX_TWO_STOP_EN
                two_stop_reg <= two_stop;
`endif
            end
            if (state_reg == DATA)
                wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
            else
                wdog_cnt_reg <= '0;
        end
    end

    // busy is low in STOP so a following byte can be accepted with no idle gap.
    assign busy      = !((state_reg == IDLE) || (state_reg == STOP));
    assign ser_en    = (state_reg == START)
                       || ((state_reg == DATA) && !ser_done && !wdog_fire);
    assign frame_err = wdog_fire;

    always_comb begin
        TX_OUT = 1'b1;
        case (state_reg)
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = ser_data;
            PARITY:  TX_OUT = par_bit_reg;
            default: TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural 8-bit serializer.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic [7:0] P_DATA;
    logic       par_en;
    logic       par_typ;
    logic       two_stop;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       busy;
    logic       TX_OUT;
    logic       frame_err;

    int n_total = 0;
    int n_bad   = 0;
    logic ser_broken = 1'b0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(8), .WDOG_LIMIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .P_DATA     (P_DATA),
        .par_en     (par_en),
        .par_typ    (par_typ),
`ifdef UART_TX_TWO_STOP_EN
        .two_stop   (two_stop),
`endif
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .busy       (busy),
        .TX_OUT     (TX_OUT),
        .frame_err  (frame_err)
    );

    // Serializer: loads while busy=0, each ser_en registers the next bit out.
    logic [7:0] sh_reg;
    logic [3:0] cnt_reg;
    logic       sd_reg;
    logic       sdone_reg;

    always @(posedge clk) begin
        if (rst) begin
            sh_reg    <= 8'h00;
            cnt_reg   <= 4'd0;
            sd_reg    <= 1'b0;
            sdone_reg <= 1'b0;
        end else if (!busy) begin
            sh_reg    <= P_DATA;
            cnt_reg   <= 4'd0;
            sdone_reg <= 1'b0;
        end else if (ser_en) begin
            sd_reg    <= sh_reg[cnt_reg[2:0]];
            cnt_reg   <= cnt_reg + 4'd1;
            sdone_reg <= (cnt_reg == 4'd7);
        end
    end

    assign ser_data = sd_reg;
    assign ser_done = sdone_reg & ~ser_broken;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept byte d at edge A, then record n cycles (first sample is the START cycle, MSB-first).
    task automatic send(input logic [7:0] d, input logic [7:0] d2, input logic pe, input logic pt,
                        input logic ts, input logic flip, input int dv_len, input int n,
                        output logic [31:0] txv, output logic [31:0] bv,
                        output logic [31:0] ev, output logic [31:0] fv);
        txv = '0; bv = '0; ev = '0; fv = '0;
        P_DATA = d; par_en = pe; par_typ = pt; two_stop = ts; data_valid = 1'b1;
        tick();
        P_DATA = d2;
        if (flip) begin
            par_en  = ~pe;
            par_typ = ~pt;
        end
        for (int i = 0; i < n; i++) begin
            if (i >= dv_len) data_valid = 1'b0;
            txv = {txv[30:0], TX_OUT};
            bv  = {bv[30:0], busy};
            ev  = {ev[30:0], ser_en};
            fv  = {fv[30:0], frame_err};
            tick();
        end
        data_valid = 1'b0;
        $display("frame d=%h pe=%b pt=%b ts=%b tx=%b busy=%b en=%b err=%b",
                 d, pe, pt, ts, txv[15:0], bv[15:0], ev[15:0], fv[15:0]);
    endtask

    logic [31:0] tx_v, busy_v, en_v, err_v;

    initial begin
        rst = 1'b1; data_valid = 1'b0; P_DATA = 8'h00;
        par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b0;
        tick(); tick();
        check("rst_tx",   32'(TX_OUT),    32'd1);
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_en",   32'(ser_en),    32'd0);
        check("rst_err",  32'(frame_err), 32'd0);
        rst = 1'b0;
        tick();

        // A5, even parity; config flipped mid-frame must not matter
        send(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, 11, tx_v, busy_v, en_v, err_v);
        check("t1_tx",   tx_v,   32'b01010010101);
        check("t1_busy", busy_v, 32'b11111111110);
        check("t1_en",   en_v,   32'b11111111000);
        check("t1_err",  err_v,  32'd0);
        check("t1_idle", 32'({busy, TX_OUT}), 32'b01);

        // 0F odd parity -> parity bit 1
        send(8'h0F, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 0, 11, tx_v, busy_v, en_v, err_v);
        check("t2a_tx",   tx_v,   32'b01111000011);
        check("t2a_busy", busy_v, 32'b11111111110);
        check("t2a_en",   en_v,   32'b11111111000);

        // 0F no parity -> 10 cycle frame
        send(8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 0, 10, tx_v, busy_v, en_v, err_v);
        check("t2b_tx",   tx_v,   32'b0111100001);
        check("t2b_busy", busy_v, 32'b1111111110);
        check("t2b_en",   en_v,   32'b1111111100);
        check("t2b_idle", 32'(busy), 32'd0);

        // Back-to-back 55 then 3C with data_valid held through busy cycles
        send(8'h55, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 12, 22, tx_v, busy_v, en_v, err_v);
        check("t3_tx",   tx_v,   32'b0101010101000111100111);
        check("t3_busy", busy_v, 32'b1111111110111111111000);
        check("t3_en",   en_v,   32'b1111111100111111110000);

        // Serializer never finishes -> watchdog
        ser_broken = 1'b1;
        send(8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 0, 11, tx_v, busy_v, en_v, err_v);
        ser_broken = 1'b0;
        check("t4_tx",   tx_v,   32'b01000000111);
        check("t4_busy", busy_v, 32'b11111111100);
        check("t4_en",   en_v,   32'b11111111000);
        check("t4_err",  err_v,  32'b00000000100);

        // Reset in the 4th DATA cycle
        P_DATA = 8'hC3; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_rst_tx",   32'(TX_OUT),    32'd1);
        check("t5_rst_busy", 32'(busy),      32'd0);
        check("t5_rst_en",   32'(ser_en),    32'd0);
        check("t5_rst_err",  32'(frame_err), 32'd0);
        rst = 1'b0;
        tick();
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 11, tx_v, busy_v, en_v, err_v);
        check("t5_tx",   tx_v,   32'b01111111111);
        check("t5_busy", busy_v, 32'b11111111100);
        check("t5_en",   en_v,   32'b11111111000);

`ifdef UART_TX_TWO_STOP_EN
        send(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12, tx_v, busy_v, en_v, err_v);
        check("t6_tx",   tx_v,   32'b000000000111);
        check("t6_busy", busy_v, 32'b111111111100);
        check("t6_en",   en_v,   32'b111111110000);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmit path.
- Accepts a byte handshake from upstream and sequences the 8-bit serializer (ser_en / ser_done).
- Computes parity and muxes start, data, parity and stop bits onto the TX line, one bit per clk (clk is the bit-rate clock).
- Drives the busy flag that gates serializer loading.
- Sits between the TX FIFO/register-file front end and the pad.

Parameters:
DATA_WIDTH, 8, byte width; must match the serializer; sets parity width.
WDOG_LIMIT, 8, maximum DATA-state cycles allowed before ser_done is treated as missing.

Ports:
clk  in  1  system/bit clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
data_valid  in  1  upstream byte strobe; accepted when busy=0
P_DATA  in  DATA_WIDTH  byte to send; same bus feeds the serializer
par_en  in  1  1 = append parity bit
par_typ  in  1  0 = even, 1 = odd
ser_data  in  1  serializer output bit (registered in serializer)
ser_done  in  1  serializer last-bit flag (high while ser_data = bit7)
ser_en  out  1  advance serializer counter
busy  out  1  frame in progress; serializer loads only when low
TX_OUT  out  1  serial line, idle high
frame_err  out  1  one-cycle pulse: ser_done missing (watchdog)

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, from any state including mid-frame:
  - state=IDLE, TX_OUT=1, busy=0, ser_en=0, frame_err=0.
  - Parity and configuration latches cleared.
- States: IDLE, START, DATA, PARITY, STOP. Outputs are decoded from registered state only, except TX_OUT in DATA, which equals ser_data.
- Acceptance: data_valid=1 and busy=0 at edge A.
  - At A: latch par_en, par_typ and the parity bit.
  - Even parity bit = XOR of P_DATA; odd = XNOR.
  - state -> START.
  - data_valid while busy=1 is ignored, with no side effects.
- START: TX_OUT=0, ser_en=1, busy=1. Next state DATA.
- DATA: TX_OUT=ser_data, busy=1, ser_en = !ser_done.
  - ser_done=1 -> PARITY if par_en was latched as 1, else STOP.
  - Nominal DATA dwell is exactly 8 cycles, carrying bits 0..7 LSB first.
- Watchdog: a cycle counter (reset on entry to DATA) counts DATA cycles.
  - If WDOG_LIMIT cycles elapse with ser_done=0: frame_err=1 for one cycle, ser_en=0, go to STOP.
  - No parity bit is sent on this path.
- PARITY: TX_OUT = latched parity bit, ser_en=0, busy=1. Next state STOP.
- STOP: TX_OUT=1, ser_en=0, busy=0 during the final stop cycle, so the next byte can be accepted in this cycle.
  - data_valid=1 -> START. Zero idle gap; the serializer reload resets its counter.
  - Otherwise -> IDLE.
- IDLE: TX_OUT=1, busy=0, ser_en=0.
- Frame length from edge A to the end of stop: 10 cycles without parity, 11 with parity.
- par_en/par_typ changes mid-frame have no effect until the next acceptance.
- ser_done outside DATA is ignored.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined:
  - Adds input port two_stop (1 bit), latched at acceptance.
  - If latched 1, an extra STOP1 state precedes STOP: TX_OUT=1, busy=1.
  - busy drops only in the final STOP, so back-to-back acceptance occurs in the second stop bit. Frame is one cycle longer.
- Undefined: the two_stop port is absent, and there is always exactly one stop bit.

Test Plan:
1. Reset, then P_DATA=8'hA5, par_en=1, par_typ=0, one-cycle data_valid.
   - Required: TX_OUT over the 11 cycles after A = 0,1,0,1,0,0,1,0,1,0,1.
   - busy=1 for 10 cycles, 0 in the stop cycle. ser_en high for 8 cycles (START + 7 DATA).
2. P_DATA=8'h0F, par_en=1, par_typ=1 -> parity bit=1. Then repeat with par_en=0 -> 10-cycle frame, no parity slot, stop directly after bit7.
3. Back-to-back: 8'h55 then 8'h3C, with data_valid held high.
   - Second START follows the first stop with zero gap.
   - Exactly 2 frames are sent; the extra data_valid cycles asserted while busy=1 are ignored.
4. Serializer model that never asserts ser_done -> frame_err pulse in the 8th DATA cycle, followed by STOP (TX_OUT=1), then IDLE; no parity bit sent.
5. rst=1 asserted in the 4th DATA cycle -> at the next edge TX_OUT=1, busy=0, ser_en=0. A new byte 8'hFF then sends cleanly: 0, eight 1s, stop.
6. With UART_TX_TWO_STOP_EN defined and two_stop=1, 8'h00, par_en=0 -> 11-cycle frame; busy=0 only in the last stop cycle.
